// File: rtl/compute_unit_sequencer.sv
// compute_unit_sequencer
// Job-level controller for one compute-unit / output-buffer pair. It takes a
// job of N filter chunks, streams filter beats into two ping-pong filter
// banks, launches one chunk computation per filled bank and reports the
// output buffer that holds the finished result.
module compute_unit_sequencer #(
  parameter int WR_CYC     = 8,
  parameter int SPM_NUM    = 16,
  parameter int BUF_NUM    = 4,
  parameter int MAX_CHUNKS = 255,
  localparam int CW = $clog2(MAX_CHUNKS + 1),
  localparam int SW = $clog2(SPM_NUM),
  localparam int BW = $clog2(BUF_NUM),
  localparam int WW = $clog2(WR_CYC)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // job request
  input  logic          job_vld_i,
  output logic          job_rdy_o,
  input  logic [CW-1:0] job_chunks_i,
  input  logic [SW-1:0] job_spm_num_i,
  input  logic [BW-1:0] job_acc_buf_i,
  // filter beat stream (data/sparsemap go straight to the compute unit)
  input  logic          flt_vld_i,
  output logic          flt_rdy_o,
  // filter bank control
  output logic          filter_wr_valid_o,
  output logic [WW-1:0] filter_wr_count_o,
  output logic          filter_wr_sel_o,
  output logic          filter_rd_sel_o,
  // compute control
  output logic          run_valid_o,
  output logic          chunk_start_o,
  output logic [SW-1:0] rd_sparsemap_num_o,
  input  logic          chunk_end_i,
  // buffers and status
  output logic [BW-1:0] acc_buf_sel_o,
  output logic [BW-1:0] out_buf_sel_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Controller state
  logic [2:0]    state_q, state_d;
  // Job parameters captured at accept
  logic [CW-1:0] chunks_q, chunks_d;
  logic [SW-1:0] spm_q, spm_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [BW-1:0] out_q, out_d;
  // Loader side: beat index inside the chunk, target bank, chunks loaded
  logic [WW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] loaded_q, loaded_d;
  // Compute side: bank being read, chunks finished
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] computed_q, computed_d;
  // Per-bank "holds a complete chunk not yet consumed" flags
  logic [1:0]    full_q, full_d;

  logic          load_act;
  logic          flt_rdy;
  logic          beat;
  logic          beat_last;
  logic          end_ok;
  logic          last_chunk;
  logic [1:0]    fill_set;
  logic [1:0]    free_clr;
  logic [1:0]    full_n;

  // Loader handshake and bank-flag update terms
  always_comb begin
    load_act   = (state_q == S_LOAD) || (state_q == S_START) ||
                 (state_q == S_RUN)  || (state_q == S_WAIT);
    flt_rdy    = load_act && !full_q[wr_bank_q] && (loaded_q < chunks_q);
    beat       = flt_vld_i && flt_rdy;
    beat_last  = beat && (wr_cnt_q == WW'(WR_CYC - 1));
    // chunk_end only counts while a chunk is actually running
    end_ok     = (state_q == S_RUN) && chunk_end_i;
    last_chunk = (computed_q + CW'(1)) == chunks_q;
    fill_set   = 2'b00;
    free_clr   = 2'b00;
    fill_set[wr_bank_q] = beat_last;
    free_clr[rd_bank_q] = end_ok;
    // Bank state including a fill finishing this cycle; the compute side
    // looks at this so a chunk starts the cycle right after its last beat.
    full_n     = full_q | fill_set;
  end

  // Next-state logic for the job FSM, loader and compute bookkeeping
  always_comb begin
    state_d    = state_q;
    chunks_d   = chunks_q;
    spm_d      = spm_q;
    acc_d      = acc_q;
    out_d      = out_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    loaded_d   = loaded_q;
    rd_bank_d  = rd_bank_q;
    computed_d = computed_q;
    // Freed and filled banks never coincide: the loader never writes a full bank
    full_d     = full_n & ~free_clr;

    if (beat) begin
      if (beat_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
        loaded_d  = loaded_q + CW'(1);
      end else begin
        wr_cnt_d  = wr_cnt_q + WW'(1);
      end
    end

    if (end_ok) begin
      rd_bank_d  = ~rd_bank_q;
      computed_d = computed_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (job_vld_i) begin
          chunks_d = job_chunks_i;
          spm_d    = job_spm_num_i;
          acc_d    = job_acc_buf_i;
          state_d  = (job_chunks_i == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD, S_WAIT: begin
        if (full_n[rd_bank_q]) state_d = S_START;
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (end_ok) begin
          if (last_chunk)              state_d = S_DONE;
          else if (full_n[~rd_bank_q]) state_d = S_START;
          else                         state_d = S_WAIT;
        end
      end
      S_DONE: begin
        // Publish the result buffer and rewind everything for the next job
        out_d      = acc_q;
        wr_cnt_d   = '0;
        wr_bank_d  = 1'b0;
        loaded_d   = '0;
        rd_bank_d  = 1'b0;
        computed_d = '0;
        full_d     = 2'b00;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any job in flight without a done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      chunks_q   <= '0;
      spm_q      <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      loaded_q   <= '0;
      rd_bank_q  <= 1'b0;
      computed_q <= '0;
      full_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      chunks_q   <= chunks_d;
      spm_q      <= spm_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      loaded_q   <= loaded_d;
      rd_bank_q  <= rd_bank_d;
      computed_q <= computed_d;
      full_q     <= full_d;
    end
  end

  // Output decode
  always_comb begin
    job_rdy_o          = (state_q == S_IDLE);
    busy_o             = (state_q != S_IDLE);
    done_o             = (state_q == S_DONE);
    flt_rdy_o          = flt_rdy;
    filter_wr_valid_o  = beat;
    filter_wr_count_o  = wr_cnt_q;
    filter_wr_sel_o    = wr_bank_q;
    filter_rd_sel_o    = rd_bank_q;
    chunk_start_o      = (state_q == S_START);
    run_valid_o        = (state_q == S_START) || (state_q == S_RUN);
    rd_sparsemap_num_o = spm_q;
    acc_buf_sel_o      = acc_q;
    out_buf_sel_o      = out_q;
  end

endmodule

// File: tb/tb_compute_unit_sequencer.sv
// Bench for compute_unit_sequencer: table of jobs plus hand sequences, with a
// scoreboard of expected filter beats and read-bank selects per job.
module tb_compute_unit_sequencer;
  localparam int WR_CYC     = 8;
  localparam int SPM_NUM    = 16;
  localparam int BUF_NUM    = 4;
  localparam int MAX_CHUNKS = 255;
  localparam int CW = $clog2(MAX_CHUNKS + 1);
  localparam int SW = $clog2(SPM_NUM);
  localparam int BW = $clog2(BUF_NUM);
  localparam int WW = $clog2(WR_CYC);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          job_vld_i;
  logic          job_rdy_o;
  logic [CW-1:0] job_chunks_i;
  logic [SW-1:0] job_spm_num_i;
  logic [BW-1:0] job_acc_buf_i;
  logic          flt_vld_i;
  logic          flt_rdy_o;
  logic          filter_wr_valid_o;
  logic [WW-1:0] filter_wr_count_o;
  logic          filter_wr_sel_o;
  logic          filter_rd_sel_o;
  logic          run_valid_o;
  logic          chunk_start_o;
  logic [SW-1:0] rd_sparsemap_num_o;
  logic          chunk_end_i;
  logic [BW-1:0] acc_buf_sel_o;
  logic [BW-1:0] out_buf_sel_o;
  logic          busy_o;
  logic          done_o;
  logic          ce_auto;
  logic          ce_man;

  assign chunk_end_i = ce_auto | ce_man;

  always #5 clk_i = ~clk_i;

  compute_unit_sequencer #(
    .WR_CYC(WR_CYC), .SPM_NUM(SPM_NUM), .BUF_NUM(BUF_NUM), .MAX_CHUNKS(MAX_CHUNKS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_vld_i(job_vld_i), .job_rdy_o(job_rdy_o),
    .job_chunks_i(job_chunks_i), .job_spm_num_i(job_spm_num_i), .job_acc_buf_i(job_acc_buf_i),
    .flt_vld_i(flt_vld_i), .flt_rdy_o(flt_rdy_o),
    .filter_wr_valid_o(filter_wr_valid_o), .filter_wr_count_o(filter_wr_count_o),
    .filter_wr_sel_o(filter_wr_sel_o), .filter_rd_sel_o(filter_rd_sel_o),
    .run_valid_o(run_valid_o), .chunk_start_o(chunk_start_o),
    .rd_sparsemap_num_o(rd_sparsemap_num_o), .chunk_end_i(chunk_end_i),
    .acc_buf_sel_o(acc_buf_sel_o), .out_buf_sel_o(out_buf_sel_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    int chunks; int spm; int bufn; int end_dly;
    int start_off; int done_off; int gap;
  } vec_t;

  int  total, bad, cyc;
  int  m_chunks, m_spm, m_buf, nb, ns, ne, acc_cyc, last_end, last_beat, last_start;
  int  done_total, cd, e, d0;
  int  exp_start_off, exp_done_off, gap_en, end_dly;
  bit  active, in_run, ob_pend, job_done, exp_rdy;
  int  beat_q[$];
  int  sel_q[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_job_rdy"},   job_rdy_o, 1);
    chk({tag, "_busy"},      busy_o, 0);
    chk({tag, "_done"},      done_o, 0);
    chk({tag, "_flt_rdy"},   flt_rdy_o, 0);
    chk({tag, "_run_valid"}, run_valid_o, 0);
    chk({tag, "_start"},     chunk_start_o, 0);
    chk({tag, "_wr_valid"},  filter_wr_valid_o, 0);
    chk({tag, "_wr_count"},  filter_wr_count_o, 0);
    chk({tag, "_wr_sel"},    filter_wr_sel_o, 0);
    chk({tag, "_rd_sel"},    filter_rd_sel_o, 0);
    chk({tag, "_spm"},       rd_sparsemap_num_o, 0);
    chk({tag, "_acc_buf"},   acc_buf_sel_o, 0);
    chk({tag, "_out_buf"},   out_buf_sel_o, 0);
  endtask

  task automatic job_go(input int ch, input int sp, input int bf);
    job_chunks_i  = CW'(ch);
    job_spm_num_i = SW'(sp);
    job_acc_buf_i = BW'(bf);
    job_vld_i     = 1'b1;
    job_done      = 1'b0;
    tick();
    job_vld_i     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!job_done && n < budget) begin
      tick();
      n++;
    end
    chk("job_timeout", job_done, 1);
  endtask

  initial begin
    rst_i = 1'b1; job_vld_i = 1'b0; job_chunks_i = '0; job_spm_num_i = '0;
    job_acc_buf_i = '0; flt_vld_i = 1'b0; ce_man = 1'b0; ce_auto = 1'b0;
    total = 0; bad = 0; cyc = 0; cd = 0; done_total = 0;
    active = 0; in_run = 0; ob_pend = 0; job_done = 0;
    nb = 0; ns = 0; ne = 0; acc_cyc = 0; last_end = 0; last_beat = 0; last_start = 0;
    m_chunks = 0; m_spm = 0; m_buf = 0;
    exp_start_off = -1; exp_done_off = 0; gap_en = 0; end_dly = 1;

    //           chunks spm buf end  start done gap
    tbl[0] = '{1,  5,  2, 11,  9,  21, 0};  // single chunk
    tbl[1] = '{4, 10,  1, 30,  9, 133, 1};  // ping-pong with loader stall
    tbl[2] = '{2,  9,  3,  7,  9,  25, 1};  // last bank-1 beat meets chunk_end
    tbl[3] = '{2,  3,  1,  3,  9,  21, 0};  // short chunk, WAIT for bank 1
    tbl[4] = '{0,  7,  3,  5, -1,   1, 0};  // zero chunks
    tbl[5] = '{3, 15,  0,  1,  9,  27, 0};  // odd count, bank reuse

    fork
      forever begin
        @(posedge clk_i);
        cyc++;
      end
      // chunk_end responder: pulses end_dly cycles after each observed start
      forever begin
        @(posedge clk_i);
        #1;
        if (cd > 0) begin
          cd--;
          ce_auto = (cd == 0);
        end else begin
          ce_auto = 1'b0;
        end
      end
      // monitor / scoreboard
      forever begin
        @(negedge clk_i);
        if (rst_i) begin
          active = 0; in_run = 0; ob_pend = 0; cd = 0;
          beat_q.delete(); sel_q.delete();
        end else begin
          if (ob_pend) begin
            chk("out_buf_sel", out_buf_sel_o, m_buf);
            chk("job_rdy_after_done", job_rdy_o, 1);
            ob_pend = 0;
          end
          if (job_vld_i && job_rdy_o) begin
            m_chunks = int'(job_chunks_i); m_spm = int'(job_spm_num_i); m_buf = int'(job_acc_buf_i);
            nb = 0; ns = 0; ne = 0; in_run = 0; acc_cyc = cyc; active = 1;
            beat_q.delete(); sel_q.delete();
            for (int i = 0; i < m_chunks * WR_CYC; i++)
              beat_q.push_back(((i / WR_CYC) % 2) * 256 + (i % WR_CYC));
            for (int i = 0; i < m_chunks; i++) sel_q.push_back(i % 2);
          end else if (active) begin
            chk("busy", busy_o, 1);
            chk("job_rdy_busy", job_rdy_o, 0);
            chk("rd_spm", rd_sparsemap_num_o, m_spm);
            chk("acc_buf", acc_buf_sel_o, m_buf);
            exp_rdy = (nb < m_chunks * WR_CYC) &&
                      !((nb % WR_CYC == 0) && (nb / WR_CYC - ne == 2));
            chk("flt_rdy", flt_rdy_o, exp_rdy);
            chk("wr_valid", filter_wr_valid_o, flt_vld_i && exp_rdy);
            chk("run_valid", run_valid_o, chunk_start_o || in_run);
            if (filter_wr_valid_o) begin
              nb++; last_beat = cyc;
              chk("beat_expected", beat_q.size() != 0, 1);
              if (beat_q.size() != 0) begin
                e = beat_q.pop_front();
                chk("wr_count", filter_wr_count_o, e % 256);
                chk("wr_sel", filter_wr_sel_o, e / 256);
              end
            end
            if (in_run && chunk_end_i) begin
              ne++; last_end = cyc; in_run = 0;
            end
            if (chunk_start_o) begin
              ns++;
              chk("start_expected", sel_q.size() != 0, 1);
              if (sel_q.size() != 0) chk("rd_sel", filter_rd_sel_o, sel_q.pop_front());
              if (ns == 1 && exp_start_off >= 0) chk("first_start_off", cyc - acc_cyc, exp_start_off);
              if (ns > 1 && gap_en != 0) chk("start_gap", cyc - last_end, 1);
              last_start = cyc; in_run = 1; cd = end_dly;
            end
            if (done_o) begin
              chk("done_off", cyc - acc_cyc, exp_done_off);
              chk("beats", nb, m_chunks * WR_CYC);
              chk("starts", ns, m_chunks);
              chk("ends", ne, m_chunks);
              chk("beat_q_left", beat_q.size(), 0);
              active = 0; ob_pend = 1; job_done = 1; done_total++;
            end
          end else begin
            chk("idle_busy", busy_o, 0);
            chk("idle_done", done_o, 0);
            chk("idle_start", chunk_start_o, 0);
          end
        end
      end
    join_none

    // reset state
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    chk_reset("rst");

    // table-driven jobs, source always valid
    foreach (tbl[k]) begin
      exp_start_off = tbl[k].start_off; exp_done_off = tbl[k].done_off;
      gap_en = tbl[k].gap; end_dly = tbl[k].end_dly; flt_vld_i = 1'b1;
      job_go(tbl[k].chunks, tbl[k].spm, tbl[k].bufn);
      wait_done(400);
    end

    // starved loader: bank-1 beats withheld until well after chunk 0 ends
    exp_start_off = 9; exp_done_off = 34; gap_en = 0; end_dly = 5; flt_vld_i = 1'b1;
    job_go(2, 4, 2);
    repeat (8) tick();
    flt_vld_i = 1'b0;
    repeat (11) tick();
    #1;
    chk("starved_run_valid", run_valid_o, 0);
    chk("starved_busy", busy_o, 1);
    chk("starved_rd_sel", filter_rd_sel_o, 1);
    flt_vld_i = 1'b1;
    wait_done(200);
    chk("starved_start_after_beat", last_start - last_beat, 1);

    // spurious chunk_end in IDLE and in LOAD
    ce_man = 1'b1;
    tick();
    ce_man = 1'b0;
    #1;
    chk("spur_idle_rdy", job_rdy_o, 1);
    chk("spur_idle_busy", busy_o, 0);
    exp_start_off = 9; exp_done_off = 21; gap_en = 0; end_dly = 11; flt_vld_i = 1'b1;
    job_go(1, 6, 3);
    tick(); tick();
    ce_man = 1'b1;
    tick();
    ce_man = 1'b0;
    wait_done(200);

    // zero-chunk requests held across DONE: second accept only in next IDLE
    exp_start_off = -1; exp_done_off = 1; gap_en = 0;
    job_chunks_i = '0; job_spm_num_i = SW'(2); job_acc_buf_i = BW'(1); job_vld_i = 1'b1;
    tick();
    #1;
    chk("zh_done1", done_o, 1);
    chk("zh_rdy_in_done", job_rdy_o, 0);
    tick();
    #1;
    chk("zh_done2", done_o, 0);
    chk("zh_rdy_idle", job_rdy_o, 1);
    job_acc_buf_i = BW'(3);
    tick();
    job_vld_i = 1'b0;
    #1;
    chk("zh_done3", done_o, 1);
    tick();

    // reset during chunk 2 of 4, then a clean single-chunk job
    exp_start_off = 9; exp_done_off = 133; gap_en = 1; end_dly = 30; flt_vld_i = 1'b1;
    job_go(4, 11, 1);
    repeat (79) tick();
    #1;
    chk("mid_run_valid", run_valid_o, 1);
    chk("mid_rd_sel", filter_rd_sel_o, 0);
    rst_i = 1'b1; flt_vld_i = 1'b0;
    tick();
    rst_i = 1'b0;
    #1;
    chk_reset("midrst");
    d0 = done_total;
    repeat (20) tick();
    chk("no_done_after_abort", done_total, d0);
    exp_start_off = 9; exp_done_off = 21; gap_en = 0; end_dly = 11; flt_vld_i = 1'b1;
    job_go(1, 5, 2);
    wait_done(200);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
